// File: rtl/csc_pkg.sv
// Shared constants for the colour-space coefficient controller: register map,
// FSM states and the four preset coefficient banks (entry 0 in the low bits).
package csc_pkg;

    localparam int COEF_W_DEF = 11;
    localparam int OFS_W_DEF  = 18;
    localparam int NREG       = 8;

    localparam logic [2:0] IDX_YGAIN = 3'd0;
    localparam logic [2:0] IDX_KR_V  = 3'd1;
    localparam logic [2:0] IDX_KG_U  = 3'd2;
    localparam logic [2:0] IDX_KG_V  = 3'd3;
    localparam logic [2:0] IDX_KB_U  = 3'd4;
    localparam logic [2:0] IDX_OFS_R = 3'd5;
    localparam logic [2:0] IDX_OFS_G = 3'd6;
    localparam logic [2:0] IDX_OFS_B = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Packed as {ofs_b, ofs_g, ofs_r, kb_u, kg_v, kg_u, kr_v, ygain}
    localparam logic [NREG*OFS_W_DEF-1:0] P0 = {18'd116589, 18'd69625, 18'd92242,
        18'd911, 18'd367, 18'd177, 18'd721, 18'd512};
    localparam logic [NREG*OFS_W_DEF-1:0] P1 = {18'd141787, 18'd69370, 18'd114131,
        18'd1033, 18'd416, 18'd200, 18'd817, 18'd596};
    localparam logic [NREG*OFS_W_DEF-1:0] P2 = {18'd147904, 18'd39360, 18'd127040,
        18'd1081, 18'd273, 18'd109, 18'd918, 18'd596};
    localparam logic [NREG*OFS_W_DEF-1:0] P3 = {18'd0, 18'd0, 18'd0,
        18'd0, 18'd0, 18'd0, 18'd0, 18'd512};

endpackage

// File: rtl/csc_preset_rom.sv
// Combinational preset table lookup: (preset, register index) -> coefficient.
module csc_preset_rom
    import csc_pkg::*;
#(
    parameter int OFS_W = OFS_W_DEF
) (
    input  logic [1:0]       sel_i,
    input  logic [2:0]       idx_i,
    output logic [OFS_W-1:0] data_o
);

    logic [NREG*OFS_W_DEF-1:0] row;

    always_comb begin
        row = P0;
        case (sel_i)
            2'd0:    row = P0;
            2'd1:    row = P1;
            2'd2:    row = P2;
            default: row = P3;
        endcase
        data_o = OFS_W'(row[idx_i*OFS_W_DEF +: OFS_W_DEF]);
    end

endmodule

// File: rtl/csc_coef_ctrl.sv
// Shadow/active coefficient banks for the YUV->RGB converter; the shadow bank is
// copied to the active bank on VS rise (or forced after VS_TIMEOUT armed cycles).
module csc_coef_ctrl
    import csc_pkg::*;
#(
    parameter int COEF_W     = COEF_W_DEF,
    parameter int OFS_W      = OFS_W_DEF,
    parameter int VS_TIMEOUT = 4194304
) (
    input  logic              vid_clk,
    input  logic              vid_rst,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [OFS_W-1:0]  cfg_wdata,
    output logic              cfg_ready,
    input  logic              preset_req,
    input  logic [1:0]        preset_sel,
    input  logic              commit_req,
    input  logic              vs_in,
    output logic [COEF_W-1:0] act_ygain,
    output logic [COEF_W-1:0] act_kr_v,
    output logic [COEF_W-1:0] act_kg_u,
    output logic [COEF_W-1:0] act_kg_v,
    output logic [COEF_W-1:0] act_kb_u,
    output logic [OFS_W-1:0]  act_ofs_r,
    output logic [OFS_W-1:0]  act_ofs_g,
    output logic [OFS_W-1:0]  act_ofs_b,
    output logic              busy,
    output logic              armed,
    output logic              cfg_updated,
    output logic              err_drop,
    output logic              timeout_flag
);

    localparam int              CNT_W    = $clog2(VS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VS_TIMEOUT - 1);

    state_t           state_q;
    logic [OFS_W-1:0] shadow_q [NREG];
    logic [OFS_W-1:0] shadow_d [NREG];
    logic [OFS_W-1:0] active_q [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       load_idx_q;
    logic [1:0]       sel_q;
    logic             vs_d_q, cfg_ready_q, busy_q, armed_q, upd_q, err_q, tmo_q;
    logic             vs_rise, start_load, wr_ok;
    logic [OFS_W-1:0] rom_data;

    function automatic logic [OFS_W-1:0] fit(input logic [2:0] idx, input logic [OFS_W-1:0] val);
        if (idx < IDX_OFS_R) return {{(OFS_W-COEF_W){1'b0}}, val[COEF_W-1:0]};
        return val;
    endfunction

    csc_preset_rom #(.OFS_W(OFS_W)) u_rom (
        .sel_i  (sel_q),
        .idx_i  (load_idx_q),
        .data_o (rom_data)
    );

    assign vs_rise    = vs_in & ~vs_d_q;
    // Preset requests outrank both register writes and a pending VS commit.
    assign start_load = preset_req && (state_q != LOAD);
    assign wr_ok      = cfg_wr && (state_q != LOAD) && !cfg_addr[3] && !preset_req;

    // Shadow bank as it will be after this cycle, so a commit sees a same-cycle write.
    always_comb begin
        for (int i = 0; i < NREG; i++) shadow_d[i] = shadow_q[i];
        if (wr_ok)
            shadow_d[cfg_addr[2:0]] = fit(cfg_addr[2:0], cfg_wdata);
        else if (state_q == LOAD)
            shadow_d[load_idx_q] = fit(load_idx_q, rom_data);
    end

    always_ff @(posedge vid_clk) begin
        if (vid_rst) begin
            state_q     <= IDLE;
            vs_d_q      <= 1'b0;
            cnt_q       <= '0;
            load_idx_q  <= '0;
            sel_q       <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= OFS_W'(P0[i*OFS_W_DEF +: OFS_W_DEF]);
                active_q[i] <= OFS_W'(P0[i*OFS_W_DEF +: OFS_W_DEF]);
            end
        end else begin
            vs_d_q <= vs_in;
            err_q  <= cfg_wr && !wr_ok;
            upd_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) shadow_q[i] <= shadow_d[i];
            if (start_load) begin
                state_q     <= LOAD;
                sel_q       <= preset_sel;
                load_idx_q  <= '0;
                cnt_q       <= '0;
                busy_q      <= 1'b1;
                cfg_ready_q <= 1'b0;
                armed_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (commit_req) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                    LOAD: begin
                        load_idx_q <= load_idx_q + 3'd1;
                        if (load_idx_q == 3'd7) begin
                            state_q     <= ARMED;
                            armed_q     <= 1'b1;
                            busy_q      <= 1'b0;
                            cfg_ready_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (vs_rise || cnt_q == CNT_LAST) begin
                            for (int i = 0; i < NREG; i++) active_q[i] <= shadow_d[i];
                            state_q <= IDLE;
                            armed_q <= 1'b0;
                            upd_q   <= 1'b1;
                            cnt_q   <= '0;
                            if (!vs_rise) tmo_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign act_ygain    = active_q[IDX_YGAIN][COEF_W-1:0];
    assign act_kr_v     = active_q[IDX_KR_V][COEF_W-1:0];
    assign act_kg_u     = active_q[IDX_KG_U][COEF_W-1:0];
    assign act_kg_v     = active_q[IDX_KG_V][COEF_W-1:0];
    assign act_kb_u     = active_q[IDX_KB_U][COEF_W-1:0];
    assign act_ofs_r    = active_q[IDX_OFS_R];
    assign act_ofs_g    = active_q[IDX_OFS_G];
    assign act_ofs_b    = active_q[IDX_OFS_B];
    assign cfg_ready    = cfg_ready_q;
    assign busy         = busy_q;
    assign armed        = armed_q;
    assign cfg_updated  = upd_q;
    assign err_drop     = err_q;
    assign timeout_flag = tmo_q;

    // Gain entries are always zero above COEF_W.
    logic unused_gain_hi;
    assign unused_gain_hi = ^{active_q[0][OFS_W-1:COEF_W], active_q[1][OFS_W-1:COEF_W],
        active_q[2][OFS_W-1:COEF_W], active_q[3][OFS_W-1:COEF_W], active_q[4][OFS_W-1:COEF_W]};

endmodule
